// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the fetch FSM state type.
package rv32i_pkg;

    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_bimm_decode.sv
// B-type immediate extraction with sign extension, plus backward-branch detect.
module bimm_decode
    import rv32i_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o,
    output logic        bwd_branch_o
);

    logic unused_bits;

    assign imm_o        = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign bwd_branch_o = (instr_i[6:0] == OP_BRANCH) && instr_i[31];
    assign unused_bits  = ^instr_i[24:12];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, stall hold, redirect with drop.
// Static backward-branch prediction is built only when FETCH_BRANCH_PREDICT_EN is defined.
module fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect_en,
    input  logic [31:0]  redirect_pc,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic         if_valid,
    output logic [31:0]  if_pc,
    output logic [31:0]  if_instr,
    output logic         if_pred_taken,
    output fetch_state_e dbg_state
);

    // imem handshake: imem_req stays high with imem_addr stable until imem_ack;
    // an ack is only honoured in a cycle where imem_req is high.
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d, redir_q, redir_d;
    logic [31:0]  if_pc_q, if_pc_d, if_instr_q, if_instr_d;
    logic         if_valid_q, if_valid_d, pred_q, pred_d;
    logic         held, ack_ok, pred_hit;
    logic [31:0]  fetch_next, redirect_aligned;

    assign held             = if_valid_q && stall;
    assign imem_req         = !rst && (((state_q == REQ) && !held) || (state_q == DROP));
    assign imem_addr        = pc_q;
    assign ack_ok           = imem_req && imem_ack;
    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_BRANCH_PREDICT_EN
    logic [31:0] bimm;
    logic        bwd_branch;

    bimm_decode u_bimm_decode (
        .instr_i      (imem_rdata),
        .imm_o        (bimm),
        .bwd_branch_o (bwd_branch)
    );

    assign pred_hit   = bwd_branch;
    assign fetch_next = bwd_branch ? (pc_q + bimm) : (pc_q + 32'd4);
`else
    assign pred_hit   = 1'b0;
    assign fetch_next = pc_q + 32'd4;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redir_d    = redir_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        pred_d     = pred_q;
        if (redirect_en) begin
            if_valid_d = 1'b0;
            pred_d     = 1'b0;
            // An unacked request must complete at its old address before the jump.
            if (imem_req && !imem_ack) begin
                state_d = DROP;
                redir_d = redirect_aligned;
            end else begin
                state_d = REQ;
                pc_d    = redirect_aligned;
            end
        end else begin
            case (state_q)
                REQ: begin
                    if (held) begin
                        state_d = HOLD;
                    end else begin
                        if_valid_d = ack_ok;
                        pred_d     = ack_ok && pred_hit;
                        if (ack_ok) begin
                            if_pc_d    = pc_q;
                            if_instr_d = imem_rdata;
                            pc_d       = fetch_next;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state_d    = REQ;
                        if_valid_d = 1'b0;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state_d = REQ;
                        pc_d    = redir_q;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= REQ;
            pc_q       <= RESET_PC;
            redir_q    <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0000_0000;
            if_instr_q <= NOP;
            pred_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redir_q    <= redir_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            pred_q     <= pred_d;
        end
    end

    assign if_valid      = if_valid_q;
    assign if_pc         = if_pc_q;
    assign if_instr      = if_instr_q;
    assign if_pred_taken = pred_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; fetched words are checked through an expected queue.
module tb_fetch_unit;
    import rv32i_pkg::*;

`ifdef FETCH_BRANCH_PREDICT_EN
    localparam logic        PRED_EXP = 1'b1;
    localparam logic [31:0] NEXT_EXP = 32'h0000_001C;
`else
    localparam logic        PRED_EXP = 1'b0;
    localparam logic [31:0] NEXT_EXP = 32'h0000_0024;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         stall = 1'b0;
    logic         redirect_en = 1'b0;
    logic [31:0]  redirect_pc = '0;
    logic         imem_ack = 1'b0;
    logic [31:0]  imem_rdata = '0;
    logic         imem_req, if_valid, if_pred_taken;
    logic [31:0]  imem_addr, if_pc, if_instr;
    fetch_state_e dbg_state;

    int checks = 0;
    int failures = 0;
    logic [64:0] exp_q[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_pc(if_pc), .if_instr(if_instr), .if_pred_taken(if_pred_taken),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] word_for(input logic [31:0] a);
        return {a[24:0] ^ 25'h0A5_A5A5, 7'h13};
    endfunction

    // Scoreboard: each newly presented instruction pops one expectation.
    logic last_valid = 1'b0;
    logic last_stall = 1'b0;
    always @(negedge clk) begin
        logic [64:0] exp;
        if (!rst && if_valid && !(last_valid && last_stall)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected actual pc=%h instr=%h required=none", if_pc, if_instr);
            end else begin
                exp = exp_q.pop_front();
                if ({if_pc, if_instr, if_pred_taken} !== exp) begin
                    failures++;
                    $display("FAIL sb_fetch actual=%h_%h_%b required=%h_%h_%b",
                             if_pc, if_instr, if_pred_taken, exp[64:33], exp[32:1], exp[0]);
                end
            end
        end
        last_valid = rst ? 1'b0 : if_valid;
        last_stall = stall;
    end

    // Called just after a rising edge; presents one memory cycle and advances a clock.
    task automatic cyc(input logic ack, input logic push, input logic [31:0] data, input logic pred);
        imem_ack   = ack;
        imem_rdata = data;
        if (ack && push) exp_q.push_back({imem_addr, data, pred});
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        checks += 5;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req actual=%b required=0", imem_req); end
        if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_valid actual=%b required=0", if_valid); end
        if (if_pc !== 32'h0) begin failures++; $display("FAIL rst_pc actual=%h required=0", if_pc); end
        if (if_instr !== 32'h0000_0013) begin failures++; $display("FAIL rst_instr actual=%h required=00000013", if_instr); end
        if (if_pred_taken !== 1'b0) begin failures++; $display("FAIL rst_pred actual=%b required=0", if_pred_taken); end
        rst = 1'b0;
        #1;
        checks += 3;
        if (imem_req !== 1'b1) begin failures++; $display("FAIL rst_first_req actual=%b required=1", imem_req); end
        if (imem_addr !== 32'h0) begin failures++; $display("FAIL rst_first_addr actual=%h required=0", imem_addr); end
        if (dbg_state !== REQ) begin failures++; $display("FAIL rst_state actual=%0d required=%0d", dbg_state, REQ); end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin
                failures++; $display("FAIL seq_addr actual=%b/%h required=1/%h", imem_req, imem_addr, 32'(i * 4));
            end
            cyc(1'b1, 1'b1, word_for(imem_addr), 1'b0);
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(i * 4)) begin
                failures++; $display("FAIL seq_latency actual=%b/%h required=1/%h", if_valid, if_pc, 32'(i * 4));
            end
        end
        cyc(1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (if_valid !== 1'b0) begin failures++; $display("FAIL seq_idle_valid actual=%b required=0", if_valid); end
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, word_for(imem_addr), 1'b0);
        stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== word_for(32'h8)) begin
                failures++;
                $display("FAIL stall_hold actual=%b/%b/%h/%h required=0/1/00000008/%h",
                         imem_req, if_valid, if_pc, if_instr, word_for(32'h8));
            end
            cyc(1'b0, 1'b0, '0, 1'b0);
        end
        stall = 1'b0;
        #1;
        n = 0;
        while (!imem_req && n < 4) begin
            cyc(1'b0, 1'b0, '0, 1'b0);
            n++;
        end
        checks++;
        if (n == 4 || imem_addr !== 32'hC) begin
            failures++; $display("FAIL stall_resume actual=%b/%h required=1/0000000c", imem_req, imem_addr);
        end
        cyc(1'b1, 1'b1, word_for(imem_addr), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_redirect_pending();
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, word_for(imem_addr), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        redirect_en = 1'b1; redirect_pc = 32'h100;
        cyc(1'b0, 1'b0, '0, 1'b0);
        redirect_en = 1'b0;
        #1;
        checks++;
        if (dbg_state !== DROP || imem_req !== 1'b1 || imem_addr !== 32'h10 || if_valid !== 1'b0) begin
            failures++;
            $display("FAIL drop_hold actual=%0d/%b/%h/%b required=%0d/1/00000010/0",
                     dbg_state, imem_req, imem_addr, if_valid, DROP);
        end
        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b0, word_for(32'h10), 1'b0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin
            failures++; $display("FAIL drop_target actual=%b/%h/%b required=1/00000100/0", imem_req, imem_addr, if_valid);
        end
        cyc(1'b1, 1'b1, word_for(imem_addr), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_redirect_ack();
        do_reset();
        cyc(1'b1, 1'b1, word_for(imem_addr), 1'b0);
        redirect_en = 1'b1; redirect_pc = 32'h203;
        cyc(1'b1, 1'b0, word_for(imem_addr), 1'b0);
        redirect_en = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            failures++; $display("FAIL redir_ack actual=%b/%b/%h required=0/1/00000200", if_valid, imem_req, imem_addr);
        end
        cyc(1'b1, 1'b1, word_for(imem_addr), 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_predict();
        do_reset();
        redirect_en = 1'b1; redirect_pc = 32'h20;
        cyc(1'b1, 1'b0, word_for(imem_addr), 1'b0);
        redirect_en = 1'b0;
        #1;
        checks++;
        if (imem_addr !== 32'h20) begin failures++; $display("FAIL pred_setup actual=%h required=00000020", imem_addr); end
        cyc(1'b1, 1'b1, 32'hFE00_0EE3, PRED_EXP);
        checks++;
        if (if_pred_taken !== PRED_EXP || imem_addr !== NEXT_EXP) begin
            failures++; $display("FAIL pred_next actual=%b/%h required=%b/%h", if_pred_taken, imem_addr, PRED_EXP, NEXT_EXP);
        end
        cyc(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc(1'b1, 1'b0, word_for(imem_addr), 1'b0);
        redirect_en = 1'b0;
        cyc(1'b1, 1'b1, word_for(imem_addr), 1'b0);
        checks++;
        if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap actual=%h/%h required=00000000/fffffffc", imem_addr, if_pc);
        end
        cyc(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(1'b1, 1'b0, word_for(imem_addr), 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0000_0013) begin
            failures++; $display("FAIL rstmid_clear actual=%b/%b/%h/%h required=0/0/00000000/00000013",
                                 imem_req, if_valid, if_pc, if_instr);
        end
        cyc(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_restart actual=%b/%h/%b required=1/00000000/0", imem_req, imem_addr, if_valid);
        end
        cyc(1'b1, 1'b1, word_for(imem_addr), 1'b0);
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
            failures++; $display("FAIL rstmid_fetch actual=%b/%h required=1/00000000", if_valid, if_pc);
        end
        cyc(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_pending();
        test_redirect_ack();
        test_predict();
        test_wrap();
        test_reset_mid();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL sb_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
